// File: rtl/pipe_hazard_ctrl.sv
// Stage-sequencing controller for the 5-stage MIPS pipeline: reset hold, memory freeze,
// RAW stalls and branch flushes. Define PIPE_PERF_EN to build the saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int RST_HOLD      = 4,
    parameter int STALL_TIMEOUT = 1023,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic             id_valid,
    input  logic [31:0]      inst_data_id,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic             is_branch_exe,
    input  logic [4:0]       regw_addr_exe,
    input  logic             wb_wen_exe,
    input  logic             is_branch_mem,
    input  logic [4:0]       regw_addr_mem,
    input  logic             wb_wen_mem,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [1:0]       pipe_state,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int WAIT_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_HOLD,
        C_FREEZE,
        C_BR_EXE,
        C_BR_MEM,
        C_STALL,
        C_NORM
    } ctl_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    ctl_t              ctl;

    logic [4:0] rs;
    logic [4:0] rt;
    logic       hit_rs;
    logic       hit_rt;
    logic       data_hazard;
    logic       unused_ok;

    assign rs = inst_data_id[25:21];
    assign rt = inst_data_id[20:16];
    assign unused_ok = ^{inst_data_id[31:26], inst_data_id[15:0]};

    // WB is not checked: the register file forwards a same-cycle write to the read port.
    assign hit_rs = rs_used && (rs != 5'd0) &&
                    ((wb_wen_exe && (rs == regw_addr_exe)) || (wb_wen_mem && (rs == regw_addr_mem)));
    assign hit_rt = rt_used && (rt != 5'd0) &&
                    ((wb_wen_exe && (rt == regw_addr_exe)) || (wb_wen_mem && (rt == regw_addr_mem)));
    assign data_hazard = id_valid && (hit_rs || hit_rt);

    always_comb begin
        if (rst || (state == ST_INIT)) ctl = C_HOLD;
        else if (mem_stall)            ctl = C_FREEZE;
        else if (is_branch_exe)        ctl = C_BR_EXE;
        else if (is_branch_mem)        ctl = C_BR_MEM;
        else if (data_hazard)          ctl = C_STALL;
        else                           ctl = C_NORM;
    end

    always_comb begin
        {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b00000;
        {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b11111;
        case (ctl)
            C_HOLD: begin
                {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
                {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b00000;
            end
            C_FREEZE: begin
                {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
            end
            C_BR_EXE: begin
                if_en   = 1'b0;
                id_rst  = 1'b1;
                exe_rst = 1'b1;
            end
            C_BR_MEM: begin
                id_rst  = 1'b1;
                exe_rst = 1'b1;
            end
            C_STALL: begin
                if_en   = 1'b0;
                id_en   = 1'b0;
                exe_rst = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            hold_cnt  <= '0;
            wait_cnt  <= '0;
            stall_err <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state <= ST_RUN;
                    else                                   hold_cnt <= hold_cnt + 1'b1;
                end
                default: begin
                    if (mem_stall) begin
                        state <= ST_FREEZE;
                        if (wait_cnt != WAIT_W'(STALL_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(STALL_TIMEOUT - 1)) stall_err <= 1'b1;
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign pipe_state = state;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] freeze_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            if ((ctl == C_STALL) && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (((ctl == C_BR_EXE) || (ctl == C_BR_MEM)) && !(&flush_q)) flush_q <= flush_q + 1'b1;
            if ((ctl == C_FREEZE) && !(&freeze_q)) freeze_q <= freeze_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign freeze_cnt = freeze_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked
// every cycle against a behavioural model of the stage-control rules.
module tb_pipe_hazard_ctrl;

    localparam int RST_HOLD = 4;
    localparam int TIMEOUT  = 8;
    localparam int CNT_W    = 32;

    logic clk = 1'b0;
    logic rst, mem_stall, id_valid, rs_used, rt_used;
    logic [31:0] inst_data_id;
    logic is_branch_exe, wb_wen_exe, is_branch_mem, wb_wen_mem;
    logic [4:0] regw_addr_exe, regw_addr_mem;
    logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic if_en, id_en, exe_en, mem_en, wb_en;
    logic [1:0] pipe_state;
    logic stall_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

    int total = 0;
    int bad   = 0;

    // model state
    bit     m_known = 0;
    int     m_phase;       // 0 INIT, 1 RUN, 2 FREEZE
    int     m_hold_left;
    int     m_stall_run;
    bit     m_err;
    longint m_stall_c, m_flush_c, m_freeze_c;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RST_HOLD(RST_HOLD), .STALL_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .id_valid(id_valid),
        .inst_data_id(inst_data_id), .rs_used(rs_used), .rt_used(rt_used),
        .is_branch_exe(is_branch_exe), .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
        .is_branch_mem(is_branch_mem), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .pipe_state(pipe_state), .stall_err(stall_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        int src [2];
        bit used [2];
        src[0]  = int'(inst_data_id[25:21]);
        src[1]  = int'(inst_data_id[20:16]);
        used[0] = rs_used;
        used[1] = rt_used;
        for (int k = 0; k < 2; k++) begin
            if (used[k] && src[k] != 0 &&
                ((wb_wen_exe && src[k] == int'(regw_addr_exe)) ||
                 (wb_wen_mem && src[k] == int'(regw_addr_mem))))
                return id_valid;
        end
        return 1'b0;
    endfunction

    // 0 hold, 1 freeze, 2 branch in EXE, 3 branch in MEM, 4 data stall, 5 normal
    function automatic int classify();
        if (rst || m_phase == 0) return 0;
        if (mem_stall)           return 1;
        if (is_branch_exe)       return 2;
        if (is_branch_mem)       return 3;
        if (m_hazard())          return 4;
        return 5;
    endfunction

    // {if,id,exe,mem,wb}_rst then {if,id,exe,mem,wb}_en
    function automatic logic [9:0] vec_for(input int cls);
        case (cls)
            0:       return 10'b11111_00000;
            1:       return 10'b00000_00000;
            2:       return 10'b01100_01111;
            3:       return 10'b01100_11111;
            4:       return 10'b00100_00111;
            default: return 10'b00000_11111;
        endcase
    endfunction

    task automatic step();
        int cls;
        #1;
        cls = (m_known || rst) ? classify() : 5;
        if (m_known || rst)
            chk("stage_ctl", {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en},
                vec_for(cls));
        if (m_known) begin
            chk("pipe_state", pipe_state, m_phase);
            chk("stall_err", stall_err, m_err);
            chk("stall_cnt", stall_cnt, m_stall_c);
            chk("flush_cnt", flush_cnt, m_flush_c);
            chk("freeze_cnt", freeze_cnt, m_freeze_c);
        end
        if (rst) begin
            m_known = 1; m_phase = 0; m_hold_left = RST_HOLD; m_stall_run = 0; m_err = 0;
            m_stall_c = 0; m_flush_c = 0; m_freeze_c = 0;
        end else if (m_phase == 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = 1;
        end else begin
`ifdef PIPE_PERF_EN
            if (cls == 4) m_stall_c++;
            if (cls == 2 || cls == 3) m_flush_c++;
            if (cls == 1) m_freeze_c++;
`endif
            if (mem_stall) begin
                m_stall_run++;
                if (m_stall_run >= TIMEOUT) m_err = 1;
                m_phase = 2;
            end else begin
                m_stall_run = 0;
                m_phase = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_stall = 0; id_valid = 0; inst_data_id = 32'h0; rs_used = 0; rt_used = 0;
        is_branch_exe = 0; regw_addr_exe = 5'd0; wb_wen_exe = 0;
        is_branch_mem = 0; regw_addr_mem = 5'd0; wb_wen_mem = 0;
    endtask

    initial begin
        int burst;
        rst = 1;
        idle_inputs();
        step();
        step();
        rst = 0;
        for (int i = 0; i < RST_HOLD; i++) step();
        chk("run_after_hold", pipe_state, 2'd1);
        step();

        // add $3,$1,$2 with $1 produced in EXE: three stall cycles
        id_valid = 1; inst_data_id = 32'h00221820; rs_used = 1; rt_used = 1;
        wb_wen_exe = 1; regw_addr_exe = 5'd1;
        for (int i = 0; i < 3; i++) step();
        inst_data_id = 32'h00021820;
        step();

        // branch flush twice, first with a coincident data hazard
        inst_data_id = 32'h00221820;
        is_branch_exe = 1; step();
        is_branch_exe = 0; is_branch_mem = 1; step();
        is_branch_exe = 1; is_branch_mem = 0; step();
        is_branch_exe = 0; is_branch_mem = 1; step();

        // freeze over a branch in MEM for five cycles
        idle_inputs();
        mem_stall = 1; is_branch_mem = 1;
        for (int i = 0; i < 5; i++) step();
`ifdef PIPE_PERF_EN
        chk("perf_stall", stall_cnt, 3);
        chk("perf_flush", flush_cnt, 4);
        chk("perf_freeze", freeze_cnt, 5);
`else
        chk("perf_stall", stall_cnt, 0);
        chk("perf_flush", flush_cnt, 0);
        chk("perf_freeze", freeze_cnt, 0);
`endif
        mem_stall = 0; step();
        is_branch_mem = 0; step();

        // memory timeout
        mem_stall = 1;
        for (int i = 0; i < 10; i++) step();
        mem_stall = 0;
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", stall_err, 1'b1);
        rst = 1; step();
        rst = 0;
        chk("err_cleared", stall_err, 1'b0);

        // random traffic
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (burst > 0) begin
                mem_stall = 1; burst--;
            end else if ($urandom_range(0, 11) == 0) begin
                mem_stall = 1; burst = $urandom_range(0, 11);
            end else begin
                mem_stall = 0;
            end
            id_valid      = ($urandom_range(0, 3) != 0);
            inst_data_id  = $urandom;
            inst_data_id[25:21] = 5'($urandom_range(0, 3));
            inst_data_id[20:16] = 5'($urandom_range(0, 3));
            rs_used       = 1'($urandom);
            rt_used       = 1'($urandom);
            is_branch_exe = ($urandom_range(0, 7) == 0);
            is_branch_mem = ($urandom_range(0, 7) == 0);
            wb_wen_exe    = 1'($urandom);
            wb_wen_mem    = 1'($urandom);
            regw_addr_exe = 5'($urandom_range(0, 3));
            regw_addr_mem = 5'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
